// File: rtl/board_input_ctrl.sv
// Purpose: board-input conditioning. Debounces CH level channels with rise/fall pulses,
//          decodes a rotary encoder into NUM_PAGES address registers, and stretches reset.
// Latency: channels 2+JITTER_MAX edges; rotary 2+ROT_JITTER+1 edges; rst_o 1 edge (rst) / 3 edges (rst_req).
// Backpressure: none; free-running pad conditioning, outputs valid every cycle.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   sig_i / sig_o     raw channel inputs / debounced levels
//   rise_o / fall_o   one-cycle pulses on debounced 0->1 / 1->0
//   rot_a, rot_b      raw rotary encoder phases
//   page_sel, addr_o  address register selector / selected address (combinational)
//   rst_req, rst_o    raw reset request / stretched reset
module board_input_ctrl #(
  parameter int              CH          = 8,
  parameter int              JITTER_MAX  = 10000,
  parameter int              CNT_W       = 16,
  parameter logic [CH-1:0]   INIT_VALUE  = {CH{1'b0}},
  parameter int              ROT_JITTER  = 2000,
  parameter int              ADDR_W      = 5,
  parameter int              NUM_PAGES   = 4,
  parameter int              WRAP        = 1,
  parameter int              RST_STRETCH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CH-1:0]                sig_i,
  output logic [CH-1:0]                sig_o,
  output logic [CH-1:0]                rise_o,
  output logic [CH-1:0]                fall_o,
  input  logic                         rot_a,
  input  logic                         rot_b,
  input  logic [$clog2(NUM_PAGES)-1:0] page_sel,
  output logic [ADDR_W-1:0]            addr_o,
  input  logic                         rst_req,
  output logic                         rst_o
);

  localparam int ROT_CNT_W = $clog2(ROT_JITTER + 1);

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers. Channel synchronisers flush to INIT_VALUE so that a
  // reset does not make sig_o see a spurious difference afterwards.
  // ---------------------------------------------------------------------------
  logic [CH-1:0] sig_s1, sig_s2;
  logic [1:0]    rot_s1, rot_s2;   // [0] = phase a, [1] = phase b
  logic          req_s1, req_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_s1 <= INIT_VALUE;
      sig_s2 <= INIT_VALUE;
      rot_s1 <= 2'b00;
      rot_s2 <= 2'b00;
      req_s1 <= 1'b0;
      req_s2 <= 1'b0;
    end else begin
      sig_s1 <= sig_i;
      sig_s2 <= sig_s1;
      rot_s1 <= {rot_b, rot_a};
      rot_s2 <= rot_s1;
      req_s1 <= rst_req;
      req_s2 <= req_s1;
    end
  end

  // ---------------------------------------------------------------------------
  // Channel debounce. The counter tracks consecutive cycles the synchronised
  // input has disagreed with sig_o; reaching JITTER_MAX commits the new level.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt [CH];

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_o  <= INIT_VALUE;
      rise_o <= '0;
      fall_o <= '0;
      for (int i = 0; i < CH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        rise_o[i] <= 1'b0;
        fall_o[i] <= 1'b0;
        if (sig_s2[i] == sig_o[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(JITTER_MAX - 1)) begin
          cnt[i]    <= '0;
          sig_o[i]  <= sig_s2[i];
          rise_o[i] <= sig_s2[i];
          fall_o[i] <= ~sig_s2[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Rotary phase debounce, same scheme. rot_rise is a registered rising-edge
  // pulse of the debounced phase; the address register consumes it one edge later.
  // ---------------------------------------------------------------------------
  logic [1:0]           rot_d;     // [0] = rot_a_d, [1] = rot_b_d
  logic [1:0]           rot_rise;
  logic [ROT_CNT_W-1:0] rot_cnt [2];

  always_ff @(posedge clk) begin
    if (rst) begin
      rot_d    <= 2'b00;
      rot_rise <= 2'b00;
      for (int p = 0; p < 2; p++) rot_cnt[p] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        rot_rise[p] <= 1'b0;
        if (rot_s2[p] == rot_d[p]) begin
          rot_cnt[p] <= '0;
        end else if (rot_cnt[p] == ROT_CNT_W'(ROT_JITTER - 1)) begin
          rot_cnt[p]  <= '0;
          rot_d[p]    <= rot_s2[p];
          rot_rise[p] <= rot_s2[p];
        end else begin
          rot_cnt[p] <= rot_cnt[p] + ROT_CNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Address registers. A phase rising while the other is low is a step; if
  // both kinds of step land together they cancel.
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] addr [NUM_PAGES];
  logic              ev_dec, ev_inc;
  logic [ADDR_W-1:0] addr_cur, addr_nxt;

  assign ev_dec   = rot_rise[0] & ~rot_d[1];
  assign ev_inc   = rot_rise[1] & ~rot_d[0];
  assign addr_cur = addr[page_sel];
  assign addr_o   = addr_cur;

  always_comb begin
    addr_nxt = addr_cur;
    if (ev_inc && !ev_dec) begin
      if (WRAP != 0 || addr_cur != {ADDR_W{1'b1}}) addr_nxt = addr_cur + ADDR_W'(1);
    end else if (ev_dec && !ev_inc) begin
      if (WRAP != 0 || addr_cur != '0) addr_nxt = addr_cur - ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_PAGES; k++) addr[k] <= '0;
    end else begin
      addr[page_sel] <= addr_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Reset stretcher. The load term is ORed into the output register so that
  // rst_o rises on the same edge the shift register is loaded; the register
  // then runs out RST_STRETCH+1 edges after the last load.
  // ---------------------------------------------------------------------------
  logic [RST_STRETCH-1:0] rst_sr;
  logic                   rst_load;

  assign rst_load = rst | req_s2;

  always_ff @(posedge clk) begin
    if (rst_load) rst_sr <= '1;
    else          rst_sr <= rst_sr << 1;
    rst_o <= rst_load | (|rst_sr);
  end

endmodule

// File: tb/tb_board_input_ctrl.sv
module tb_board_input_ctrl;
  localparam int            CH   = 4;
  localparam int            JM   = 4;
  localparam int            RJ   = 2;
  localparam int            AW   = 5;
  localparam int            NP   = 4;
  localparam int            RS   = 16;
  localparam int            PW   = 2;
  localparam int            AMAX = (1 << AW) - 1;
  localparam logic [CH-1:0] INIT = 4'b1000;
  localparam int            MAXT = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, rot_a, rot_b, rst_req;
  logic [CH-1:0] sig_i;
  logic [PW-1:0] page_sel;

  logic [CH-1:0] sig_w, rise_w, fall_w, sig_s, rise_s, fall_s;
  logic [AW-1:0] addr_w, addr_s;
  logic          rsto_w, rsto_s;

  board_input_ctrl #(.CH(CH), .JITTER_MAX(JM), .CNT_W(4), .INIT_VALUE(INIT), .ROT_JITTER(RJ),
                     .ADDR_W(AW), .NUM_PAGES(NP), .WRAP(1), .RST_STRETCH(RS)) dut_wrap (
    .clk(clk), .rst(rst), .sig_i(sig_i), .sig_o(sig_w), .rise_o(rise_w), .fall_o(fall_w),
    .rot_a(rot_a), .rot_b(rot_b), .page_sel(page_sel), .addr_o(addr_w),
    .rst_req(rst_req), .rst_o(rsto_w));

  board_input_ctrl #(.CH(CH), .JITTER_MAX(JM), .CNT_W(4), .INIT_VALUE(INIT), .ROT_JITTER(RJ),
                     .ADDR_W(AW), .NUM_PAGES(NP), .WRAP(0), .RST_STRETCH(RS)) dut_sat (
    .clk(clk), .rst(rst), .sig_i(sig_i), .sig_o(sig_s), .rise_o(rise_s), .fall_o(fall_s),
    .rot_a(rot_a), .rot_b(rot_b), .page_sel(page_sel), .addr_o(addr_s),
    .rst_req(rst_req), .rst_o(rsto_s));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: edge-indexed history of raw inputs. A synchronised value at
  // edge e is the raw value sampled at edge e-2. A level commits when the last
  // J synchronised samples (all after the last reset) agree and differ from it.
  // The stretched reset is high while some load edge lies within the last RS edges.
  // ---------------------------------------------------------------------------
  logic [CH-1:0] raw_sig [MAXT];
  bit            raw_a [MAXT], raw_b [MAXT], raw_req [MAXT];
  int            t = 0, last_rst = -1000000, last_load = -1000000;
  bit            started = 0;
  logic [CH-1:0] m_sig, m_rise, m_fall;
  bit            m_ad, m_bd, m_ra, m_rb, m_rsto;
  int            m_aw [NP], m_as [NP];

  function automatic bit syn(input int e, input int kind, input int ch);
    logic [CH-1:0] iv;
    iv = INIT;
    if (e - 2 <= last_rst) return (kind == 0) ? iv[ch] : 1'b0;
    case (kind)
      0:       return raw_sig[e-2][ch];
      1:       return raw_a[e-2];
      2:       return raw_b[e-2];
      default: return raw_req[e-2];
    endcase
  endfunction

  function automatic bit stable(input int e, input int j, input int kind, input int ch, output bit v);
    bit x;
    v = 1'b0;
    if (e - j + 1 <= last_rst) return 1'b0;
    x = syn(e, kind, ch);
    for (int i = 1; i < j; i++) if (syn(e - i, kind, ch) != x) return 1'b0;
    v = x;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    bit v, dec, inc;
    int d, sv;
    t++;
    if (t >= MAXT) begin
      $display("FAIL model_overrun: t=%0d limit=%0d", t, MAXT);
      $fatal(1);
    end
    raw_sig[t] = sig_i; raw_a[t] = rot_a; raw_b[t] = rot_b; raw_req[t] = rst_req;
    if (rst) begin
      started = 1; last_rst = t; last_load = t;
      m_sig = INIT; m_rise = '0; m_fall = '0;
      m_ad = 0; m_bd = 0; m_ra = 0; m_rb = 0;
      for (int k = 0; k < NP; k++) begin m_aw[k] = 0; m_as[k] = 0; end
    end else if (started) begin
      dec = m_ra && !m_bd;
      inc = m_rb && !m_ad;
      if (dec != inc) begin
        d = inc ? 1 : -1;
        m_aw[page_sel] = (m_aw[page_sel] + d + AMAX + 1) % (AMAX + 1);
        sv = m_as[page_sel] + d;
        m_as[page_sel] = (sv < 0) ? 0 : (sv > AMAX) ? AMAX : sv;
      end
      for (int c = 0; c < CH; c++) begin
        m_rise[c] = 1'b0; m_fall[c] = 1'b0;
        if (stable(t, JM, 0, c, v) && v != m_sig[c]) begin
          m_sig[c] = v; m_rise[c] = v; m_fall[c] = !v;
        end
      end
      m_ra = 0; m_rb = 0;
      if (stable(t, RJ, 1, 0, v) && v != m_ad) begin m_ad = v; m_ra = v; end
      if (stable(t, RJ, 2, 0, v) && v != m_bd) begin m_bd = v; m_rb = v; end
      if (syn(t, 3, 0)) last_load = t;
    end
    m_rsto = (last_load >= t - RS);
  end

  task automatic compare_all();
    if (!started) return;
    chk("sig_o_wrap", sig_w, m_sig);
    chk("sig_o_sat",  sig_s, m_sig);
    chk("rise_o",     rise_w, m_rise);
    chk("fall_o",     fall_w, m_fall);
    chk("addr_wrap",  addr_w, m_aw[page_sel]);
    chk("addr_sat",   addr_s, m_as[page_sel]);
    chk("rst_o",      rsto_w, m_rsto);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic rot_pulse(input bit a, input bit b);
    rot_a = a; rot_b = b;
    repeat (8) step();
    rot_a = 0; rot_b = 0;
    repeat (8) step();
  endtask

  initial begin
    int first, cnt, seen;
    rst = 1; sig_i = INIT; rot_a = 0; rot_b = 0; rst_req = 0; page_sel = '0;
    repeat (3) step();
    chk("reset_sig_o", sig_w, INIT);
    chk("reset_addr", addr_w, 0);
    chk("reset_rst_o", rsto_w, 1);
    chk("reset_pulses", {rise_w, fall_w}, 0);
    rst = 0;
    repeat (20) step();
    chk("rst_o_idle", rsto_w, 0);

    // clean step on channel 0
    sig_i[0] = 1'b1;
    first = -1; cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (rise_w[0]) begin cnt++; if (first < 0) first = k; end
    end
    chk("deb_latency", first, 2 + JM);
    chk("deb_rise_count", cnt, 1);
    chk("deb_level", sig_w[0], 1);
    chk("deb_others", sig_w[2:1], 0);

    // 3-cycle glitch on channel 1
    seen = 0;
    sig_i[1] = 1'b1;
    repeat (3) begin step(); seen |= int'(sig_w[1] | rise_w[1] | fall_w[1]); end
    sig_i[1] = 1'b0;
    repeat (10) begin step(); seen |= int'(sig_w[1] | rise_w[1] | fall_w[1]); end
    chk("glitch_reject", seen, 0);

    // rotary: wrap vs saturate, page isolation, coincident edges
    page_sel = 0;
    rot_pulse(1, 0);
    chk("wrap_dec", addr_w, AMAX);
    chk("sat_dec", addr_s, 0);
    rot_pulse(0, 1);
    rot_pulse(0, 1);
    chk("wrap_inc2", addr_w, 1);
    chk("sat_inc2", addr_s, 2);
    page_sel = 2; #1;
    chk("page2_view", addr_w, 0);
    page_sel = 0; #1;
    chk("page0_hold", addr_w, 1);
    rot_pulse(1, 1);
    chk("coincident_wrap", addr_w, 1);
    chk("coincident_sat", addr_s, 2);

    // reset stretch, single request
    rst_req = 1; first = -1; cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 1) rst_req = 0;
      if (rsto_w) begin cnt++; if (first < 0) first = k; end
    end
    chk("stretch_assert_lat", first, 3);
    chk("stretch_len", cnt, RS + 1);

    // second request 8 cycles into stretching restarts the count
    rst_req = 1; cnt = 0;
    for (int k = 1; k <= 50; k++) begin
      step();
      if (k == 1 || k == 11) rst_req = 0;
      if (k == 10) rst_req = 1;
      if (rsto_w) cnt++;
    end
    chk("stretch_restart_len", cnt, 8 + RS + 3);

    // reset while channel 2 is three counts into a pending change
    sig_i[2] = 1'b1;
    repeat (5) step();
    rst = 1;
    step();
    chk("midrst_sig_o", sig_w, INIT);
    chk("midrst_pulses", {rise_w, fall_w}, 0);
    chk("midrst_rst_o", rsto_w, 1);
    for (int p = 0; p < NP; p++) begin
      page_sel = PW'(p); #1;
      chk("midrst_addr", addr_w, 0);
    end
    rst = 0; sig_i = INIT; page_sel = 0;
    repeat (4) step();

    // randomized traffic against the model
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(5) == 0) sig_i[$urandom_range(CH - 1)] ^= 1'b1;
      if ($urandom_range(4) == 0) rot_a = ~rot_a;
      if ($urandom_range(4) == 0) rot_b = ~rot_b;
      if ($urandom_range(7) == 0) page_sel = PW'($urandom_range(NP - 1));
      rst_req = ($urandom_range(99) == 0);
      rst     = ($urandom_range(399) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
